// File: rtl/glyph_row_serializer.sv
// Purpose: renders one ROWS x COLS glyph from a combinational font-row ROM as a
//          serial pixel stream, with SCALE-fold horizontal and vertical repetition.
// Latency: first pix_valid 2 cycles after start is sampled; one LOAD bubble per scaled line.
// Backpressure: pix_valid/pix_on/pix_eol/pix_eof hold stable until pix_ready accepts the beat.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start / busy / done start request (honoured in IDLE), activity flag, end-of-glyph pulse
//   row_addr / row_code font ROM row index and its same-cycle row data (MSB = leftmost pixel)
//   pix_valid / pix_ready / pix_on / pix_eol / pix_eof  pixel stream with line/frame markers
module glyph_row_serializer #(
    parameter int SCALE = 2,
    parameter int ROWS  = 6,
    parameter int COLS  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic [2:0]      row_addr,
    input  logic [COLS-1:0] row_code,
    output logic            pix_valid,
    input  logic            pix_ready,
    output logic            pix_on,
    output logic            pix_eol,
    output logic            pix_eof,
    output logic            done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [2:0] S_LAST = 3'(SCALE - 1);
    localparam logic [2:0] C_LAST = 3'(COLS - 1);
    localparam logic [2:0] R_LAST = 3'(ROWS - 1);

    state_t          state;
    logic [COLS-1:0] shreg;
    logic [2:0]      row;
    logic [2:0]      col;
    logic [2:0]      hrep;
    logic [2:0]      vrep;

    logic at_eol;
    logic at_eof;
    logic accept;

    // Line/frame markers are decoded from the current beat position so they
    // stay aligned with pix_on while the consumer stalls.
    assign at_eol = (col == C_LAST) && (hrep == S_LAST);
    assign at_eof = at_eol && (row == R_LAST) && (vrep == S_LAST);
    assign accept = (state == SHIFT) && pix_ready;

    // All outputs are pure decodes of flops, so they are glitch-free and
    // collapse to 0 the moment reset clears the state and counters.
    assign busy      = (state != IDLE);
    assign done      = (state == FIN);
    assign pix_valid = (state == SHIFT);
    assign pix_on    = (state == SHIFT) && shreg[COLS-1];
    assign pix_eol   = (state == SHIFT) && at_eol;
    assign pix_eof   = (state == SHIFT) && at_eof;
    assign row_addr  = row;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            row   <= '0;
            col   <= '0;
            hrep  <= '0;
            vrep  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        row   <= '0;
                        vrep  <= '0;
                        state <= LOAD;
                    end
                end

                LOAD: begin
                    // ROM is combinational on row_addr, so the row is captured directly.
                    shreg <= row_code;
                    col   <= '0;
                    hrep  <= '0;
                    state <= SHIFT;
                end

                SHIFT: begin
                    if (accept) begin
                        if (hrep != S_LAST) begin
                            hrep <= hrep + 3'd1;
                        end else begin
                            hrep  <= '0;
                            shreg <= {shreg[COLS-2:0], 1'b0};
                            // col is parked at 0 after the last column so it never
                            // steps past its range; LOAD re-clears it anyway.
                            col   <= (col == C_LAST) ? 3'd0 : col + 3'd1;
                        end

                        if (at_eol) begin
                            if (vrep != S_LAST) begin
                                vrep  <= vrep + 3'd1;
                                state <= LOAD;
                            end else begin
                                vrep <= '0;
                                if (row != R_LAST) begin
                                    row   <= row + 3'd1;
                                    state <= LOAD;
                                end else begin
                                    state <= FIN;
                                end
                            end
                        end
                    end
                end

                FIN: begin
                    // Single-cycle done; a start seen here is dropped, not queued.
                    row   <= '0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_glyph_row_serializer.sv
module tb_glyph_row_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       st = 1'b0;
    logic       rdy = 1'b1;
    logic       sel2 = 1'b0;

    logic       start1, start2;
    logic       busy1, busy2;
    logic [2:0] row_addr1, row_addr2;
    logic [4:0] row_code1, row_code2;
    logic       pv1, pv2, on1, on2, eol1, eol2, eof1, eof2, done1, done2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Digit-2 font: rows MSB = leftmost pixel.
    function automatic logic [4:0] rom(input logic [2:0] a);
        case (a)
            3'd0:    rom = 5'b01110;
            3'd1:    rom = 5'b10001;
            3'd2:    rom = 5'b00010;
            3'd3:    rom = 5'b00100;
            3'd4:    rom = 5'b01000;
            3'd5:    rom = 5'b11111;
            default: rom = 5'b00000;
        endcase
    endfunction

    assign row_code1 = rom(row_addr1);
    assign row_code2 = rom(row_addr2);
    assign start1 = st & ~sel2;
    assign start2 = st & sel2;

    glyph_row_serializer #(.SCALE(1), .ROWS(6), .COLS(5)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1),
        .row_addr(row_addr1), .row_code(row_code1),
        .pix_valid(pv1), .pix_ready(rdy), .pix_on(on1),
        .pix_eol(eol1), .pix_eof(eof1), .done(done1)
    );

    glyph_row_serializer #(.SCALE(2), .ROWS(6), .COLS(5)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2),
        .row_addr(row_addr2), .row_code(row_code2),
        .pix_valid(pv2), .pix_ready(rdy), .pix_on(on2),
        .pix_eol(eol2), .pix_eof(eof2), .done(done2)
    );

    wire       m_busy = sel2 ? busy2 : busy1;
    wire       m_pv   = sel2 ? pv2   : pv1;
    wire       m_on   = sel2 ? on2   : on1;
    wire       m_eol  = sel2 ? eol2  : eol1;
    wire       m_eof  = sel2 ? eof2  : eof1;
    wire       m_done = sel2 ? done2 : done1;
    wire [2:0] m_row  = sel2 ? row_addr2 : row_addr1;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        st = 1'b0;
        rdy = 1'b1;
        step;
        step;
        checks++;
        if ({busy1, pv1, on1, eol1, eof1, done1, row_addr1} !== 9'd0) begin
            errors++;
            $display("FAIL reset_s1: outputs=%b expected 0", {busy1, pv1, on1, eol1, eof1, done1, row_addr1});
        end
        checks++;
        if ({busy2, pv2, on2, eol2, eof2, done2, row_addr2} !== 9'd0) begin
            errors++;
            $display("FAIL reset_s2: outputs=%b expected 0", {busy2, pv2, on2, eol2, eof2, done2, row_addr2});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step;
    endtask

    // Renders one glyph on the selected instance and checks every beat against
    // a position model derived from the beat index.
    task automatic run_glyph(input int s, input int stall_at, input int stall_len,
                             input bit poke_start, input string name);
        int total, k, loads, eols, eofs, stalled, line, w, r, v, c, h;
        bit was_stall, exp_done, got_done, exp_eol, exp_eof, exp_on;
        logic [4:0] code;

        total = 30 * s * s;
        k = 0; loads = 1; eols = 0; eofs = 0; stalled = 0;
        was_stall = 1'b0; exp_done = 1'b0; got_done = 1'b0;
        sel2 = (s == 2);
        rdy = 1'b1;
        st = 1'b1;
        step;
        st = 1'b0;
        checks++;
        if (m_busy !== 1'b1 || m_pv !== 1'b0) begin
            errors++;
            $display("FAIL %s_load_cycle: busy=%b pix_valid=%b expected busy=1 pix_valid=0", name, m_busy, m_pv);
        end
        step;
        checks++;
        if (m_pv !== 1'b1) begin
            errors++;
            $display("FAIL %s_first_valid: pix_valid=%b expected 1 two cycles after start", name, m_pv);
        end

        for (int cyc = 0; cyc < 2000 && !got_done; cyc++) begin
            if (cyc > 0) step;
            st = 1'b0;
            if (exp_done) begin
                checks++;
                if (m_done !== 1'b1 || m_busy !== 1'b1 || m_pv !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_done: done=%b busy=%b pix_valid=%b expected 1,1,0", name, m_done, m_busy, m_pv);
                end
                got_done = 1'b1;
                if (poke_start) st = 1'b1;
            end else begin
                if (was_stall) begin
                    checks++;
                    if (m_pv !== 1'b1) begin
                        errors++;
                        $display("FAIL %s_stall_hold: pix_valid=%b expected 1 while stalled", name, m_pv);
                    end
                end
                if (m_pv === 1'b1) begin
                    if (k >= total) begin
                        errors++;
                        $display("FAIL %s_extra_beat: beat %0d beyond expected %0d", name, k, total);
                        break;
                    end
                    line = k / (5 * s);
                    r = line / s;
                    v = line % s;
                    w = k % (5 * s);
                    c = w / s;
                    h = w % s;
                    code = rom(3'(r));
                    exp_on = code[4 - c];
                    exp_eol = (c == 4) && (h == s - 1);
                    exp_eof = exp_eol && (r == 5) && (v == s - 1);
                    checks++;
                    if ({m_on, m_eol, m_eof, m_row} !== {exp_on, exp_eol, exp_eof, 3'(r)}) begin
                        errors++;
                        $display("FAIL %s_beat%0d: on/eol/eof/row=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                                 name, k, m_on, m_eol, m_eof, m_row, exp_on, exp_eol, exp_eof, r);
                    end
                    if (k == stall_at && stalled < stall_len) begin
                        rdy = 1'b0;
                        stalled++;
                        was_stall = 1'b1;
                    end else begin
                        rdy = 1'b1;
                        was_stall = 1'b0;
                        if (m_eol === 1'b1) eols++;
                        if (m_eof === 1'b1) eofs++;
                        if (exp_eof) exp_done = 1'b1;
                        k++;
                        if (poke_start && k == 7) st = 1'b1;
                    end
                end else begin
                    was_stall = 1'b0;
                    rdy = 1'b1;
                    if (m_done === 1'b1) begin
                        errors++;
                        $display("FAIL %s_early_done: done=1 after %0d beats, expected %0d", name, k, total);
                    end else if (m_busy === 1'b1) begin
                        loads++;
                    end
                end
            end
        end
        if (!got_done) begin
            errors++;
            $display("FAIL %s_timeout: glyph did not complete, beats=%0d", name, k);
        end

        step;
        st = 1'b0;
        checks++;
        if (m_busy !== 1'b0 || m_done !== 1'b0) begin
            errors++;
            $display("FAIL %s_after_fin: busy=%b done=%b expected 0,0", name, m_busy, m_done);
        end
        for (int i = 0; i < 3; i++) begin
            step;
            checks++;
            if (m_busy !== 1'b0 || m_done !== 1'b0) begin
                errors++;
                $display("FAIL %s_idle%0d: busy=%b done=%b expected 0,0", name, i, m_busy, m_done);
            end
        end
        checks++;
        if (k != total || loads != 6 * s || eols != 6 * s || eofs != 1) begin
            errors++;
            $display("FAIL %s_totals: beats=%0d loads=%0d eols=%0d eofs=%0d expected %0d/%0d/%0d/1",
                     name, k, loads, eols, eofs, total, 6 * s, 6 * s);
        end
    endtask

    task automatic test_scale1;
        run_glyph(1, -1, 0, 1'b0, "scale1");
    endtask

    task automatic test_scale2;
        run_glyph(2, -1, 0, 1'b0, "scale2");
    endtask

    task automatic test_backpressure;
        // Row 1, col 0 is beat 5 at SCALE=1 (foreground pixel).
        run_glyph(1, 5, 3, 1'b0, "bp");
    endtask

    task automatic test_start_ignored;
        run_glyph(1, -1, 0, 1'b1, "start_ign");
        run_glyph(1, -1, 0, 1'b0, "fresh");
    endtask

    task automatic test_reset_mid;
        int k;
        bit hit;
        k = 0;
        hit = 1'b0;
        sel2 = 1'b0;
        rdy = 1'b1;
        st = 1'b1;
        step;
        st = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            step;
            if (pv1 === 1'b1) begin
                if (k == 17) begin
                    hit = 1'b1;
                    break;
                end
                k++;
            end
        end
        checks++;
        if (!hit || row_addr1 !== 3'd3 || on1 !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_reach: hit=%b row_addr=%0d pix_on=%b expected 1,3,1", hit, row_addr1, on1);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy1, pv1, on1, eol1, eof1, done1, row_addr1} !== 9'd0) begin
            errors++;
            $display("FAIL rst_mid_async: outputs=%b expected 0", {busy1, pv1, on1, eol1, eof1, done1, row_addr1});
        end
        for (int i = 0; i < 3; i++) begin
            step;
            checks++;
            if (done1 !== 1'b0 || busy1 !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_hold%0d: done=%b busy=%b expected 0,0", i, done1, busy1);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        step;
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_release: busy=%b done=%b expected 0,0", busy1, done1);
        end
        run_glyph(1, -1, 0, 1'b0, "after_rst");
    endtask

    initial begin
        test_reset;
        test_scale1;
        test_scale2;
        test_backpressure;
        test_start_ignored;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
